sha256_cand_gen: RTL and testbench
==================================

# sha256_cand_gen

Brute-force candidate generator that sits directly upstream of `sha256_core`. It enumerates every string over a selectable prefix of the 36-symbol alphabet (a–z, then 0–9), for lengths `len_min`..`len_max`. Each candidate is emitted as a fully padded single 512-bit SHA-256 block over a valid/ready handshake. One instance feeds one core; multiple instances can split the keyspace (see Configuration).

## Interface
- `MAX_LEN`, 8: largest supported string length in bytes, range 1..55.
- `IDX_W`, 32: width of `cand_index`.

- `clk`  in  1  system clock; the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  begin enumeration; sampled only in IDLE.
- `abort`  in  1  stop enumeration; takes effect at the next edge.
- `len_min`  in  6  shortest length.
- `len_max`  in  6  longest length.
- `charset_last`  in  6  index of the last symbol used (2 = a–c, 35 = a–z0–9).
- `blk_valid`  out  1  `block` holds a candidate.
- `blk_ready`  in  1  the core accepts the block.
- `block`  out  512  padded SHA-256 message block.
- `cand_len`  out  6  length of the current candidate.
- `cand_index`  out  IDX_W  count of candidates transferred since `start`.
- `busy`  out  1  high from IDLE exit until DONE.
- `done`  out  1  one-cycle pulse at the end of a run.
- `error`  out  1  configuration rejected; held until the next `start`.

## Operation
- Symbol map: index 0..25 → 0x61..0x7A; index 26..35 → 0x30..0x39.
- Digit registers `d[0..MAX_LEN-1]` count 0..`charset_last`. `d[0]` is the first (leftmost) message byte. `d[cand_len-1]` increments fastest, in odometer order.
- Block layout for length L:
  - `block[511 -: 8L]` = symbols `d[0]`..`d[L-1]`, first symbol in the MSBs.
  - The next byte is 0x80.
  - Zeros follow.
  - `block[63:0]` = 8L.
- States: IDLE, CHECK, EMIT, DONE.
- IDLE → CHECK on `start`. `len_min`, `len_max` and `charset_last` are latched at that edge.
- CHECK rejects the configuration if any of these hold: `len_min`=0, `len_min`>`len_max`, `len_max`>MAX_LEN, `charset_last`>35. On reject: `error`=1, go to DONE, no candidate is ever emitted. Otherwise: all digits = 0, `cand_len`=`len_min`, `cand_index`=0, go to EMIT.
- EMIT:
  - `blk_valid`=1.
  - On transfer (`blk_valid`&`blk_ready`): `cand_index`+1 (wraps modulo 2^IDX_W), advance the digits.
  - If all used digits equal `charset_last` and `cand_len`<`len_max`: `cand_len`+1, digits = 0.
  - If all used digits equal `charset_last` and `cand_len`=`len_max`: go to DONE.
- DONE: `done`=1 for one cycle, `busy`=0, then IDLE.
- `abort` in CHECK or EMIT → DONE at the next edge. Any pending block is dropped. `error` is unchanged.
- `start` outside IDLE is ignored.

## Timing
- Reset values: `blk_valid`=0, `block`=0, `cand_len`=0, `cand_index`=0, `busy`=0, `done`=0, `error`=0, state IDLE. Reset mid-run applies these at the same edge, with no final `done`.
- `start` sampled at edge N → `busy`=1 after N. With a valid configuration, `blk_valid`=1 and the first block appear after N+1.
- All outputs are registered.
- While `blk_valid`=1 and `blk_ready`=0, `block`, `cand_len` and `cand_index` hold stable.
- Transfer at edge M → the next candidate appears after M with `blk_valid` still 1. There is no bubble, so throughput is one candidate per cycle while `blk_ready`=1.
- The final transfer at edge M → `blk_valid`=0 and `done`=1 after M. `done` clears after M+1.
- `blk_valid` never falls without a transfer, except on `abort` or `reset`.

## Configuration
- `SHA256_CAND_PART_EN` defined:
  - Adds inputs `part_lo[5:0]` and `part_hi[5:0]`, latched at `start`.
  - `d[0]` iterates only `part_lo`..`part_hi`. When `d[0]` would pass `part_hi`, the current length is exhausted.
  - CHECK additionally rejects `part_lo`>`part_hi` and `part_hi`>`charset_last`.
  - Lets two instances split the keyspace for two cores.
- Not defined: no extra ports; `d[0]` spans 0..`charset_last`.

## Test plan
- `len_min`=`len_max`=1, `charset_last`=2, `blk_ready`=1 → three blocks "a", "b", "c". The "a" block is 0x6180 followed by zeros, with a final word of 0x…0008. Then `done` pulse with `cand_index`=3.
- `len_min`=1, `len_max`=2, `charset_last`=1 → order a, b, aa, ab, ba, bb. `cand_len` steps 1→2 after the 2nd transfer; `done` after the 6th.
- Same as the first scenario with `blk_ready` toggling pseudo-randomly → `block` is stable while stalled, no candidate is duplicated or skipped, 3 transfers total.
- `len_min`=`len_max`=5, `charset_last`=0 → a single block 0x616161616180…0028, matching the core's known "aaaaa" digest path. Then `done`.
- `len_min`=3, `len_max`=2 → `error`=1, `done` pulse 2 cycles after `start`, `blk_valid` never 1. Separately, `reset` asserted mid-EMIT → all outputs return to reset values at that edge.
- With `SHA256_CAND_PART_EN`: `part_lo`=`part_hi`=1, length 2, `charset_last`=2 → ba, bb, bc, then `done`.

Source files
------------

// File: rtl/sha256_cand_gen.sv
// sha256_cand_gen
//   Brute-force candidate generator feeding one sha256_core. Enumerates every
//   string over the first (charset_last+1) symbols of "a..z0..9" for lengths
//   len_min..len_max, in odometer order (rightmost symbol fastest). Each
//   candidate is presented as a fully padded single 512-bit SHA-256 block
//   over a valid/ready handshake, one candidate per cycle while ready is high.
//
//   Optional feature macro: SHA256_CAND_PART_EN
//     When defined, i_part_lo/i_part_hi restrict the leftmost symbol to
//     part_lo..part_hi so several instances can split the keyspace.
//
// Ports
//   i_clk, i_reset       clock, synchronous active-high reset
//   i_start, i_abort     begin run (sampled in IDLE) / stop run
//   i_len_min/max        length range, latched at start
//   i_charset_last       last symbol index used, latched at start
//   i_part_lo/hi         (macro only) leftmost symbol range, latched at start
//   o_blk_valid/i_blk_ready, o_block   candidate block handshake
//   o_cand_len, o_cand_index           current length / transfers so far
//   o_busy, o_done, o_error            run status
module sha256_cand_gen #(
    parameter int MAX_LEN = 8,
    parameter int IDX_W   = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic [5:0]       i_len_min,
    input  logic [5:0]       i_len_max,
    input  logic [5:0]       i_charset_last,
`ifdef SHA256_CAND_PART_EN
    input  logic [5:0]       i_part_lo,
    input  logic [5:0]       i_part_hi,
`endif
    output logic             o_blk_valid,
    input  logic             i_blk_ready,
    output logic [511:0]     o_block,
    output logic [5:0]       o_cand_len,
    output logic [IDX_W-1:0] o_cand_index,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_error
);

    localparam logic [5:0] LEN_LIM = 6'(MAX_LEN);

    typedef enum logic [1:0] {S_IDLE, S_CHECK, S_EMIT, S_DONE} state_t;

    state_t                  r_state;
    logic [5:0]              r_lmin, r_lmax, r_cs;
    logic [MAX_LEN-1:0][5:0] r_d;           // r_d[0] is the leftmost byte

    logic [5:0]              w_lo0, w_hi0;  // range of the leftmost digit
    logic                    w_cfg_bad;
    logic [MAX_LEN-1:0][5:0] w_init, w_adv, w_nxt_d, w_sel_d;
    logic [5:0]              w_nxt_len, w_sel_len;
    logic                    w_carry, w_exh;
    logic [511:0]            w_blk;

`ifdef SHA256_CAND_PART_EN
    logic [5:0] r_plo, r_phi;
    assign w_lo0     = r_plo;
    assign w_hi0     = r_phi;
    assign w_cfg_bad = (r_lmin == 6'd0) || (r_lmin > r_lmax) || (r_lmax > LEN_LIM) ||
                       (r_cs > 6'd35) || (r_plo > r_phi) || (r_phi > r_cs);
`else
    assign w_lo0     = 6'd0;
    assign w_hi0     = r_cs;
    assign w_cfg_bad = (r_lmin == 6'd0) || (r_lmin > r_lmax) || (r_lmax > LEN_LIM) ||
                       (r_cs > 6'd35);
`endif

    // Symbol index -> ASCII: 0..25 = 'a'..'z', 26..35 = '0'..'9'
    function automatic logic [7:0] f_sym(input logic [5:0] idx);
        if (idx < 6'd26) return 8'h61 + {2'b00, idx};
        else             return 8'h30 + {2'b00, idx} - 8'd26;
    endfunction

    // Message bytes, 0x80 terminator, zero fill, 64-bit bit-length trailer
    function automatic logic [511:0] f_block(input logic [MAX_LEN-1:0][5:0] d,
                                             input logic [5:0] len);
        logic [511:0] b;
        b = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (6'(i) < len)       b[511-8*i -: 8] = f_sym(d[i]);
            else if (6'(i) == len) b[511-8*i -: 8] = 8'h80;
        end
        // full-length string: terminator lands just past the digit bytes
        if (len == LEN_LIM) b[511-8*MAX_LEN -: 8] = 8'h80;
        b[63:0] = {55'b0, len, 3'b000};
        return b;
    endfunction

    // Odometer step over the used digits; carry out means length exhausted
    always_comb begin
        w_adv   = r_d;
        w_carry = 1'b1;
        for (int i = MAX_LEN-1; i >= 0; i--) begin
            if ((6'(i) < o_cand_len) && w_carry) begin
                if (r_d[i] == ((i == 0) ? w_hi0 : r_cs)) begin
                    w_adv[i] = (i == 0) ? w_lo0 : 6'd0;
                end else begin
                    w_adv[i] = r_d[i] + 6'd1;
                    w_carry  = 1'b0;
                end
            end
        end
        w_exh = w_carry;

        w_init    = '0;
        w_init[0] = w_lo0;

        w_nxt_d   = w_exh ? w_init : w_adv;
        w_nxt_len = w_exh ? o_cand_len + 6'd1 : o_cand_len;

        // One block builder shared by the first candidate and every successor
        w_sel_d   = (r_state == S_CHECK) ? w_init : w_nxt_d;
        w_sel_len = (r_state == S_CHECK) ? r_lmin : w_nxt_len;
        w_blk     = f_block(w_sel_d, w_sel_len);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= S_IDLE;
            r_lmin       <= '0;
            r_lmax       <= '0;
            r_cs         <= '0;
            r_d          <= '0;
`ifdef SHA256_CAND_PART_EN
            r_plo        <= '0;
            r_phi        <= '0;
`endif
            o_blk_valid  <= 1'b0;
            o_block      <= '0;
            o_cand_len   <= '0;
            o_cand_index <= '0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_error      <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_lmin  <= i_len_min;
                        r_lmax  <= i_len_max;
                        r_cs    <= i_charset_last;
`ifdef SHA256_CAND_PART_EN
                        r_plo   <= i_part_lo;
                        r_phi   <= i_part_hi;
`endif
                        o_busy  <= 1'b1;
                        o_error <= 1'b0;
                        r_state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (i_abort || w_cfg_bad) begin
                        o_error <= o_error | (w_cfg_bad & ~i_abort);
                        o_busy  <= 1'b0;
                        o_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_d          <= w_init;
                        o_cand_len   <= r_lmin;
                        o_cand_index <= '0;
                        o_block      <= w_blk;
                        o_blk_valid  <= 1'b1;
                        r_state      <= S_EMIT;
                    end
                end
                S_EMIT: begin
                    if (i_abort) begin
                        o_blk_valid <= 1'b0;
                        o_busy      <= 1'b0;
                        o_done      <= 1'b1;
                        r_state     <= S_DONE;
                    end else if (i_blk_ready) begin
                        o_cand_index <= o_cand_index + IDX_W'(1);
                        if (w_exh && (o_cand_len == r_lmax)) begin
                            o_blk_valid <= 1'b0;
                            o_busy      <= 1'b0;
                            o_done      <= 1'b1;
                            r_state     <= S_DONE;
                        end else begin
                            // next candidate replaces the accepted one, no bubble
                            r_d        <= w_nxt_d;
                            o_cand_len <= w_nxt_len;
                            o_block    <= w_blk;
                        end
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_cand_gen.sv
// Testbench for sha256_cand_gen: directed scenarios plus randomized
// configurations and ready patterns, checked against an enumeration model.
module tb_sha256_cand_gen;

    localparam int MAX_LEN = 8;
    localparam int IDX_W   = 32;

    logic             clk = 1'b0;
    logic             reset, start, abort, blk_ready;
    logic [5:0]       len_min, len_max, cs;
`ifdef SHA256_CAND_PART_EN
    logic [5:0]       part_lo, part_hi;
`endif
    logic             blk_valid, busy, done, error;
    logic [511:0]     block;
    logic [5:0]       cand_len;
    logic [IDX_W-1:0] cand_index;

    int               n_assert = 0;
    int               n_fail   = 0;
    logic [511:0]     q_blk[$];
    int               q_len[$];
    logic [511:0]     first_blk;

    sha256_cand_gen #(.MAX_LEN(MAX_LEN), .IDX_W(IDX_W)) dut (
        .i_clk(clk), .i_reset(reset), .i_start(start), .i_abort(abort),
        .i_len_min(len_min), .i_len_max(len_max), .i_charset_last(cs),
`ifdef SHA256_CAND_PART_EN
        .i_part_lo(part_lo), .i_part_hi(part_hi),
`endif
        .o_blk_valid(blk_valid), .i_blk_ready(blk_ready), .o_block(block),
        .o_cand_len(cand_len), .o_cand_index(cand_index),
        .o_busy(busy), .o_done(done), .o_error(error)
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic flag(input string tag);
        n_assert++;
        n_fail++;
        $error("FAIL %s", tag);
    endtask

    function automatic logic [7:0] sym(input int i);
        return (i < 26) ? 8'(97 + i) : 8'(48 + i - 26);
    endfunction

    // Candidate n of length L is n written in mixed radix: leftmost digit
    // spans plo..phi, the others 0..cs.
    task automatic build_model(input int lmin, input int lmax, input int cs_i,
                               input int plo, input int phi);
        int base, tot, m;
        int dig[MAX_LEN];
        logic [511:0] b;
        q_blk.delete();
        q_len.delete();
        base = cs_i + 1;
        for (int L = lmin; L <= lmax; L++) begin
            tot = phi - plo + 1;
            for (int j = 1; j < L; j++) tot = tot * base;
            for (int n = 0; n < tot; n++) begin
                m = n;
                for (int p = L - 1; p >= 1; p--) begin
                    dig[p] = m % base;
                    m      = m / base;
                end
                dig[0] = plo + m;
                b = '0;
                for (int p = 0; p < L; p++) b = b | ({504'b0, sym(dig[p])} << (504 - 8*p));
                b = b | ({504'b0, 8'h80} << (504 - 8*L));
                b[63:0] = 64'(8*L);
                q_blk.push_back(b);
                q_len.push_back(L);
            end
        end
    endtask

    task automatic drive_cfg(input int lmin, input int lmax, input int cs_i,
                             input int plo, input int phi);
        len_min = 6'(lmin);
        len_max = 6'(lmax);
        cs      = 6'(cs_i);
`ifdef SHA256_CAND_PART_EN
        part_lo = 6'(plo);
        part_hi = 6'(phi);
`endif
    endtask

    task automatic run(input int lmin, input int lmax, input int cs_i,
                       input int plo_in, input int phi_in, input bit rnd);
        int  k, cyc, plo, phi;
        bit  fin;
`ifdef SHA256_CAND_PART_EN
        plo = plo_in;
        phi = phi_in;
`else
        plo = 0;
        phi = cs_i;
`endif
        build_model(lmin, lmax, cs_i, plo, phi);
        k = 0; cyc = 0; fin = 0;
        first_blk = 'x;
        @(negedge clk);
        drive_cfg(lmin, lmax, cs_i, plo_in, phi_in);
        start = 1; blk_ready = 0;
        @(negedge clk);
        start = 0;
        check("busy_after_start", busy, 1);
        check("valid_after_start", blk_valid, 0);
        check("error_cleared", error, 0);
        while (!fin && cyc < 20 * q_blk.size() + 50) begin
            @(negedge clk);
            cyc++;
            if (done) begin
                fin = 1;
            end else if (blk_valid) begin
                if (k < q_blk.size()) begin
                    check("block", block, q_blk[k]);
                    check("cand_len", cand_len, q_len[k]);
                    check("cand_index", cand_index, k);
                    if (k == 0) first_blk = block;
                end else begin
                    flag("extra_candidate");
                end
                blk_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                if (blk_ready) k++;
            end else begin
                flag("valid_dropped_without_done");
            end
        end
        if (!fin) flag("timeout_waiting_done");
        check("transfer_count", k, q_blk.size());
        check("final_index", cand_index, q_blk.size());
        check("valid_at_done", blk_valid, 0);
        check("busy_at_done", busy, 0);
        blk_ready = 0;
        @(negedge clk);
        check("done_one_cycle", done, 0);
    endtask

    task automatic errcfg(input int lmin, input int lmax, input int cs_i,
                          input int plo, input int phi);
        @(negedge clk);
        drive_cfg(lmin, lmax, cs_i, plo, phi);
        start = 1;
        @(negedge clk);
        start = 0;
        check("err_busy", busy, 1);
        @(negedge clk);
        check("err_done", done, 1);
        check("err_flag", error, 1);
        check("err_valid", blk_valid, 0);
        check("err_busy_low", busy, 0);
        @(negedge clk);
        check("err_done_clr", done, 0);
        check("err_held", error, 1);
        check("err_valid2", blk_valid, 0);
    endtask

    initial begin
        int lmn, lmx, c;
        reset = 1; start = 0; abort = 0; blk_ready = 0;
        drive_cfg(0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        check("rst_valid", blk_valid, 0);
        check("rst_block", block, 0);
        check("rst_len", cand_len, 0);
        check("rst_index", cand_index, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        reset = 0;

        run(1, 1, 2, 0, 2, 0);
        check("blk_a_literal", first_blk, {16'h6180, 432'b0, 64'h8});
        run(1, 2, 1, 0, 1, 0);
        run(1, 1, 2, 0, 2, 1);
        run(5, 5, 0, 0, 0, 0);
        check("blk_aaaaa_literal", first_blk, {40'h6161616161, 8'h80, 400'b0, 64'h28});
        run(1, 1, 35, 0, 35, 1);
        run(MAX_LEN, MAX_LEN, 0, 0, 0, 0);

        errcfg(3, 2, 2, 0, 2);
        errcfg(0, 1, 2, 0, 2);
        errcfg(1, MAX_LEN + 1, 2, 0, 2);
        errcfg(1, 1, 36, 0, 35);

        for (int r = 0; r < 4; r++) begin
            lmn = $urandom_range(1, 3);
            lmx = $urandom_range(lmn, 3);
            c   = $urandom_range(0, 4);
            run(lmn, lmx, c, 0, c, 1);
        end

        // abort mid-run
        @(negedge clk);
        drive_cfg(1, 2, 3, 0, 3);
        start = 1;
        @(negedge clk);
        start = 0; blk_ready = 1;
        repeat (3) @(negedge clk);
        abort = 1;
        @(negedge clk);
        abort = 0; blk_ready = 0;
        check("abort_valid", blk_valid, 0);
        check("abort_done", done, 1);
        check("abort_busy", busy, 0);
        check("abort_error", error, 0);
        @(negedge clk);
        check("abort_done_clr", done, 0);

        // reset mid-EMIT
        drive_cfg(2, 2, 3, 0, 3);
        start = 1;
        @(negedge clk);
        start = 0; blk_ready = 1;
        repeat (4) @(negedge clk);
        check("pre_reset_valid", blk_valid, 1);
        reset = 1;
        @(negedge clk);
        check("mid_rst_valid", blk_valid, 0);
        check("mid_rst_block", block, 0);
        check("mid_rst_len", cand_len, 0);
        check("mid_rst_index", cand_index, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_error", error, 0);
        reset = 0; blk_ready = 0;
        @(negedge clk);
        check("post_rst_done", done, 0);
        check("post_rst_valid", blk_valid, 0);

`ifdef SHA256_CAND_PART_EN
        run(2, 2, 2, 1, 1, 0);
        check("part_first_ba", first_blk, {16'h6261, 8'h80, 424'b0, 64'h10});
        run(1, 2, 3, 2, 3, 1);
        errcfg(1, 1, 2, 2, 1);
        errcfg(1, 1, 2, 0, 3);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
